// File: rtl/pmem_arb_pkg.sv
// Shared types for the physical-memory arbiter: FSM state, grant id and the
// saturating increment used by the optional performance counters
// (PMEM_ARB_PERF_EN).
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  localparam int PERF_CNT_WIDTH = 32;

  // Add one when en is set, but stick at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(
    input logic [PERF_CNT_WIDTH-1:0] value,
    input logic                      en
  );
    logic [PERF_CNT_WIDTH-1:0] result;
    if (en && (value != {PERF_CNT_WIDTH{1'b1}})) begin
      result = value + {{(PERF_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/pmem_arb_perf_cnt.sv
// Grant / conflict event counters for pmem_arbiter. Only compiled when
// PMEM_ARB_PERF_EN is defined; all counters saturate at all-ones.
`ifdef PMEM_ARB_PERF_EN
module pmem_arb_perf_cnt
  import pmem_arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      grant_i_evt,
  input  logic                      grant_d_evt,
  input  logic                      conflict_evt,
  output logic [PERF_CNT_WIDTH-1:0] perf_i_grants,
  output logic [PERF_CNT_WIDTH-1:0] perf_d_grants,
  output logic [PERF_CNT_WIDTH-1:0] perf_conflicts
);

  // Count each event once per cycle it is seen, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_grants  <= {PERF_CNT_WIDTH{1'b0}};
      perf_d_grants  <= {PERF_CNT_WIDTH{1'b0}};
      perf_conflicts <= {PERF_CNT_WIDTH{1'b0}};
    end else begin
      perf_i_grants  <= sat_inc(perf_i_grants, grant_i_evt);
      perf_d_grants  <= sat_inc(perf_d_grants, grant_d_evt);
      perf_conflicts <= sat_inc(perf_conflicts, conflict_evt);
    end
  end

endmodule
`endif

// File: rtl/pmem_arbiter.sv
// Two-port (icache / dcache) arbiter in front of a single cacheline memory.
// Round-robin on conflicts, one transaction in flight, registered memory
// strobes, combinational response routing. Define PMEM_ARB_PERF_EN to add
// grant/conflict performance counter outputs.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int CACHELINE_BIT_WIDTH = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  // icache side
  input  logic                           i_pmem_read,
  input  logic [ADDR_WIDTH-1:0]          i_pmem_address,
  output logic [CACHELINE_BIT_WIDTH-1:0] i_pmem_rdata,
  output logic                           i_pmem_resp,
  // dcache side
  input  logic                           d_pmem_read,
  input  logic                           d_pmem_write,
  input  logic [ADDR_WIDTH-1:0]          d_pmem_address,
  input  logic [CACHELINE_BIT_WIDTH-1:0] d_pmem_wdata,
  output logic [CACHELINE_BIT_WIDTH-1:0] d_pmem_rdata,
  output logic                           d_pmem_resp,
  // memory side
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic [CACHELINE_BIT_WIDTH-1:0] mem_wdata,
  input  logic [CACHELINE_BIT_WIDTH-1:0] mem_rdata,
  input  logic                           mem_resp
`ifdef PMEM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0]      perf_i_grants,
  output logic [PERF_CNT_WIDTH-1:0]      perf_d_grants,
  output logic [PERF_CNT_WIDTH-1:0]      perf_conflicts
`endif
);

  arb_state_e state_r;
  grant_e     last_grant_r;

  logic i_req_s;
  logic d_req_s;
  logic grant_i_s;
  logic grant_d_s;

  // Decide which requester (if any) wins this IDLE cycle.
  always_comb begin
    i_req_s   = i_pmem_read;
    d_req_s   = d_pmem_read | d_pmem_write;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (i_req_s && d_req_s) begin
        if (last_grant_r == GRANT_D) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b1;
        end
      end else if (i_req_s) begin
        grant_i_s = 1'b1;
      end else if (d_req_s) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Route the memory response to the owner of the current transaction only.
  always_comb begin
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    if (state_r == SERVE_I) begin
      i_pmem_resp = mem_resp;
    end else if (state_r == SERVE_D) begin
      d_pmem_resp = mem_resp;
    end else begin
      i_pmem_resp = 1'b0;
      d_pmem_resp = 1'b0;
    end
  end

  // Read data is shared by both caches; only resp qualifies it.
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  // Arbitration FSM; memory strobes are latched at grant and held to mem_resp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_D;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_address  <= {ADDR_WIDTH{1'b0}};
      mem_wdata    <= {CACHELINE_BIT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_i_s) begin
            state_r     <= SERVE_I;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= i_pmem_address;
          end else if (grant_d_s) begin
            // A simultaneous read+write from the dcache is a write.
            state_r     <= SERVE_D;
            mem_read    <= ~d_pmem_write;
            mem_write   <= d_pmem_write;
            mem_address <= d_pmem_address;
            mem_wdata   <= d_pmem_wdata;
          end else begin
            state_r   <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            state_r      <= IDLE;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            last_grant_r <= GRANT_I;
          end else begin
            state_r <= SERVE_I;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            state_r      <= IDLE;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            last_grant_r <= GRANT_D;
          end else begin
            state_r <= SERVE_D;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

`ifdef PMEM_ARB_PERF_EN
  logic conflict_s;

  // A conflict is any IDLE cycle where both caches are asking.
  always_comb begin
    conflict_s = 1'b0;
    if (state_r == IDLE) begin
      conflict_s = i_req_s & d_req_s;
    end else begin
      conflict_s = 1'b0;
    end
  end

  pmem_arb_perf_cnt u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .grant_i_evt    (grant_i_s),
    .grant_d_evt    (grant_d_s),
    .conflict_evt   (conflict_s),
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
  );
`endif

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter CACHELINE_BIT_WIDTH, default 256, line width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports i_pmem_read  input  1; i_pmem_address  input  ADDR_WIDTH  (icache request).
REQ-006 SHALL have ports i_pmem_rdata  output  CACHELINE_BIT_WIDTH; i_pmem_resp  output  1  (icache return).
REQ-007 SHALL have ports d_pmem_read, d_pmem_write  input  1; d_pmem_address  input  ADDR_WIDTH; d_pmem_wdata  input  CACHELINE_BIT_WIDTH  (dcache request).
REQ-008 SHALL have ports d_pmem_rdata  output  CACHELINE_BIT_WIDTH; d_pmem_resp  output  1  (dcache return).
REQ-009 SHALL have ports mem_read, mem_write  output  1; mem_address  output  ADDR_WIDTH; mem_wdata  output  CACHELINE_BIT_WIDTH  (memory side).
REQ-010 SHALL have ports mem_rdata  input  CACHELINE_BIT_WIDTH; mem_resp  input  1.

Function
REQ-011 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-012 IDLE, only icache requesting: SHALL go to SERVE_I next edge, latching i_pmem_address.
REQ-013 IDLE, only dcache requesting (read or write): SHALL go to SERVE_D, latching address, wdata, op.
REQ-014 IDLE, both requesting: SHALL grant the requester not granted last (round-robin via 1-bit last_grant); after reset last_grant=D, so icache wins first conflict.
REQ-015 mem_read/mem_write/mem_address/mem_wdata SHALL be registered from latched values: request seen cycle N, memory strobe asserted cycle N+1.
REQ-016 dcache read and write both asserted SHALL be treated as write; mem_read and mem_write SHALL never assert together.
REQ-017 In SERVE_x, strobes SHALL hold stable until the cycle mem_resp=1.
REQ-018 On mem_resp in SERVE_x: x_pmem_resp=1 that same cycle (combinational), strobes drop next edge, state -> IDLE, last_grant <= x.
REQ-019 i_pmem_rdata and d_pmem_rdata SHALL both equal mem_rdata combinationally; only resp is gated.
REQ-020 Non-granted requester's resp SHALL stay 0; mem_resp in IDLE SHALL be ignored.
REQ-021 Requester deasserting mid-transaction SHALL not abort it; transaction completes on latched values.
REQ-022 Back-to-back: minimum one IDLE cycle between consecutive memory transactions.

Reset
REQ-023 On rst: state=IDLE, last_grant=D, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, both resps 0, immediately and asynchronously, including mid-transaction.
REQ-024 After rst deassert, first grant no earlier than first rising edge with a request.

Configuration
REQ-025 Macro PMEM_ARB_PERF_EN defined: SHALL add outputs perf_i_grants, perf_d_grants, perf_conflicts (32 bits each, saturating at all-ones, reset 0), incremented at grant edges and at IDLE cycles with both requesting.
REQ-026 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-027 FSM state enum and grant-id enum SHALL live in shared package pmem_arb_pkg.
REQ-028 Single module; optional sub-module pmem_arb_perf_cnt holds counters under PMEM_ARB_PERF_EN.

Verification
REQ-029 Icache read 0x0000_1000 alone, mem_resp after 5 cycles -> mem_read=1 one cycle later, i_pmem_resp=1 one cycle, d_pmem_resp=0.
REQ-030 Both request same cycle after reset (i 0x100, d write 0x200) -> icache served first, dcache next with mem_write=1, mem_wdata matching.
REQ-031 Both continuously requesting for 4 transactions -> grants alternate I,D,I,D.
REQ-032 rst asserted mid SERVE_D -> mem_write=0 same cycle, state IDLE, no resp issued.
REQ-033 d_pmem_read and d_pmem_write both 1 -> only mem_write=1.
REQ-034 With PMEM_ARB_PERF_EN, 3 conflicts and 5 grants -> perf_conflicts=3, grant counters sum 5.
